// File: rtl/pc_gen_pkg.sv
// Shared definitions for the fetch-PC generator: transfer opcodes, default reset PC,
// controller states and return-address-stack operation kinds.
package pc_gen_pkg;

  typedef enum logic [3:0] {
    OP_NEXT = 4'd0,
    OP_BEQ  = 4'd1,
    OP_BNE  = 4'd2,
    OP_BLEZ = 4'd3,
    OP_BGTZ = 4'd4,
    OP_BLTZ = 4'd5,
    OP_BGEZ = 4'd6,
    OP_J    = 4'd7,
    OP_JR   = 4'd8
  } trans_op_e;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;

  typedef enum logic {
    ST_RUN,
    ST_HOLD
  } state_e;

  typedef enum logic [1:0] {
    RAS_NONE,
    RAS_PUSH,
    RAS_POP
  } ras_op_e;

endpackage

// File: rtl/pc_gen_ras.sv
// Circular return-address stack: a push on a full stack overwrites the oldest entry,
// a pop on an empty stack is ignored, and hit_o pulses when the popped top matches.
module pc_gen_ras #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic [WIDTH-1:0] pop_cmp_i,
  output logic             hit_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             hit_q;
  logic [PTR_W-1:0] top_idx;

  assign top_idx = ptr_q - PTR_W'(1);
  assign hit_o   = hit_q;

  // NOTE: the stack storage is deliberately left out of reset; the count already marks every entry invalid.
  always_ff @(posedge clk) begin
    if (push_i) begin
      mem_q[ptr_q] <= push_data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      ptr_q   <= '0;
      count_q <= '0;
      hit_q   <= 1'b0;
    end else begin
      hit_q <= 1'b0;
      if (push_i) begin
        ptr_q <= ptr_q + PTR_W'(1);
        if (count_q != CNT_W'(DEPTH)) begin
          count_q <= count_q + CNT_W'(1);
        end
      end else if (pop_i && (count_q != '0)) begin
        ptr_q   <= top_idx;
        count_q <= count_q - CNT_W'(1);
        hit_q   <= (mem_q[top_idx] == pop_cmp_i);
      end
    end
  end

endmodule

// File: rtl/pc_gen.sv
// Fetch PC generator with D-stage branch/jump redirect and stall-time pending redirect.
// Optional return-address stack is built only when PC_GEN_RAS_EN is defined.
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_PC  = WIDTH'(RESET_PC_DEFAULT),
  parameter int               RAS_DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             br_valid,
  input  logic [3:0]       trans_op,
  input  logic             link,
  input  logic             is_ret,
  input  logic [WIDTH-1:0] pc_d,
  input  logic [WIDTH-1:0] cmp_a,
  input  logic [WIDTH-1:0] cmp_b,
  input  logic [15:0]      offset,
  input  logic [25:0]      instr_index,
  input  logic [WIDTH-1:0] reg_target,
  output logic [WIDTH-1:0] pc_f,
  output logic             redirect,
  output logic [WIDTH-1:0] link_addr,
  output logic             ras_hit
);

  if (WIDTH < 32) begin : g_bad_width
    $error("pc_gen: WIDTH must be at least 32");
  end
  if ((RAS_DEPTH < 2) || ((RAS_DEPTH & (RAS_DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("pc_gen: RAS_DEPTH must be a power of two, at least 2");
  end

  state_e           state_q;
  logic [WIDTH-1:0] pc_q;
  logic [WIDTH-1:0] pend_target_q;
  logic [WIDTH-1:0] pend_push_data_q;
  ras_op_e          pend_ras_q;

  logic             pend_valid;
  logic             cond;
  logic             taken;
  logic [WIDTH-1:0] seq_pc;
  logic [WIDTH-1:0] br_target;
  logic [WIDTH-1:0] j_target;
  logic [WIDTH-1:0] target;
  ras_op_e          ras_op_now;

  logic             ras_push;
  logic             ras_pop;
  logic [WIDTH-1:0] ras_push_data;
  logic [WIDTH-1:0] ras_cmp;

  assign pend_valid = (state_q == ST_HOLD);
  assign link_addr  = pc_d + WIDTH'(8);
  assign pc_f       = pc_q;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    seq_pc     = pc_d + WIDTH'(4);
    br_target  = seq_pc + ({{(WIDTH-16){offset[15]}}, offset} << 2);
    j_target   = {seq_pc[WIDTH-1:28], instr_index, 2'b00};
    cond       = 1'b0;
    target     = br_target;
    ras_op_now = RAS_NONE;
    case (trans_op)
      OP_BEQ:  cond = (cmp_a == cmp_b);
      OP_BNE:  cond = (cmp_a != cmp_b);
      OP_BLEZ: cond = cmp_a[WIDTH-1] || (cmp_a == '0);
      OP_BGTZ: cond = !cmp_a[WIDTH-1] && (cmp_a != '0);
      OP_BLTZ: cond = cmp_a[WIDTH-1];
      OP_BGEZ: cond = !cmp_a[WIDTH-1];
      OP_J: begin
        cond   = 1'b1;
        target = j_target;
        if (link) ras_op_now = RAS_PUSH;
      end
      OP_JR: begin
        cond   = 1'b1;
        target = reg_target;
        if (is_ret) ras_op_now = RAS_POP;
      end
      default: cond = 1'b0;
    endcase
  end

  // A held transfer takes priority; new D-stage transfers are only accepted with nothing pending.
  assign taken    = br_valid && !pend_valid && cond;
  assign redirect = !stall && (pend_valid || taken);

  always_comb begin
    ras_push      = 1'b0;
    ras_pop       = 1'b0;
    ras_push_data = link_addr;
    ras_cmp       = reg_target;
    if (pend_valid) begin
      ras_push      = !stall && (pend_ras_q == RAS_PUSH);
      ras_pop       = !stall && (pend_ras_q == RAS_POP);
      ras_push_data = pend_push_data_q;
      ras_cmp       = pend_target_q;
    end else begin
      ras_push = !stall && taken && (ras_op_now == RAS_PUSH);
      ras_pop  = !stall && taken && (ras_op_now == RAS_POP);
    end
  end

  // NOTE: all sequential state is written with non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q          <= ST_RUN;
      pc_q             <= RESET_PC;
      pend_target_q    <= '0;
      pend_push_data_q <= '0;
      pend_ras_q       <= RAS_NONE;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (!stall) begin
            pc_q <= taken ? target : pc_q + WIDTH'(4);
          end else if (taken) begin
            state_q          <= ST_HOLD;
            pend_target_q    <= target;
            pend_push_data_q <= link_addr;
            pend_ras_q       <= ras_op_now;
          end
        end
        ST_HOLD: begin
          if (!stall) begin
            state_q    <= ST_RUN;
            pc_q       <= pend_target_q;
            pend_ras_q <= RAS_NONE;
          end
        end
        default: state_q <= ST_RUN;
      endcase
    end
  end

`ifdef PC_GEN_RAS_EN
  pc_gen_ras #(
    .WIDTH (WIDTH),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk         (clk),
    .reset       (reset),
    .push_i      (ras_push),
    .pop_i       (ras_pop),
    .push_data_i (ras_push_data),
    .pop_cmp_i   (ras_cmp),
    .hit_o       (ras_hit)
  );
`else
  logic unused_ras;
  assign unused_ras = ^{ras_push, ras_pop, ras_push_data, ras_cmp};
  assign ras_hit    = 1'b0;
`endif

endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen: directed scenarios plus randomized traffic, all
// compared against a behavioural model of fetch PC, pending redirect and return stack.
module tb_pc_gen;

  localparam int          RAS_DEPTH = 4;
  localparam logic [31:0] RESET_PC  = 32'h0000_3000;
`ifdef PC_GEN_RAS_EN
  localparam bit RAS_ON = 1'b1;
`else
  localparam bit RAS_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        br_valid;
  logic [3:0]  trans_op;
  logic        link;
  logic        is_ret;
  logic [31:0] pc_d;
  logic [31:0] cmp_a;
  logic [31:0] cmp_b;
  logic [15:0] offset;
  logic [25:0] instr_index;
  logic [31:0] reg_target;
  logic [31:0] pc_f;
  logic        redirect;
  logic [31:0] link_addr;
  logic        ras_hit;

  pc_gen #(
    .WIDTH     (32),
    .RESET_PC  (RESET_PC),
    .RAS_DEPTH (RAS_DEPTH)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .stall       (stall),
    .br_valid    (br_valid),
    .trans_op    (trans_op),
    .link        (link),
    .is_ret      (is_ret),
    .pc_d        (pc_d),
    .cmp_a       (cmp_a),
    .cmp_b       (cmp_b),
    .offset      (offset),
    .instr_index (instr_index),
    .reg_target  (reg_target),
    .pc_f        (pc_f),
    .redirect    (redirect),
    .link_addr   (link_addr),
    .ras_hit     (ras_hit)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  logic [31:0] m_pc;
  bit          m_pend;
  logic [31:0] m_pend_tgt;
  int          m_pend_kind;   // 0 none, 1 push, 2 pop
  logic [31:0] m_pend_data;
  bit          m_hit;
  logic [31:0] ras[$];
  bit          last_redirect;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic bit m_taken(input int op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      1:       return a == b;
      2:       return a != b;
      3:       return $signed(a) <= 0;
      4:       return $signed(a) > 0;
      5:       return $signed(a) < 0;
      6:       return $signed(a) >= 0;
      7, 8:    return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] m_target(input int op);
    int s;
    s = $signed(offset);
    if (op == 7) return ((pc_d + 32'd4) & 32'hF000_0000) | (32'(instr_index) * 32'd4);
    if (op == 8) return reg_target;
    return pc_d + 32'd4 + 32'(s * 4);
  endfunction

  task automatic ras_apply(input int kind, input logic [31:0] data, input logic [31:0] cmp);
    if (!RAS_ON) return;
    if (kind == 1) begin
      ras.push_back(data);
      if (ras.size() > RAS_DEPTH) void'(ras.pop_front());
    end else if (kind == 2 && ras.size() > 0) begin
      m_hit = (ras[$] == cmp);
      void'(ras.pop_back());
    end
  endtask

  // One clock cycle: inputs are already driven; check combinational outputs, advance model, check registered outputs.
  task automatic tick();
    bit          exp_redir;
    bit          tk;
    logic [31:0] tg;
    int          kind;
    #1;
    check("link_addr", link_addr, pc_d + 32'd8);
    exp_redir = 1'b0;
    if (!reset) begin
      m_pc   = RESET_PC;
      m_pend = 1'b0;
      m_hit  = 1'b0;
      ras.delete();
    end else begin
      m_hit = 1'b0;
      if (m_pend) begin
        exp_redir = !stall;
        if (!stall) begin
          m_pc = m_pend_tgt;
          ras_apply(m_pend_kind, m_pend_data, m_pend_tgt);
          m_pend = 1'b0;
        end
      end else begin
        tk   = br_valid && m_taken(int'(trans_op), cmp_a, cmp_b);
        tg   = m_target(int'(trans_op));
        kind = (trans_op == 4'd7 && link) ? 1 : (trans_op == 4'd8 && is_ret) ? 2 : 0;
        exp_redir = tk && !stall;
        if (stall) begin
          if (tk) begin
            m_pend      = 1'b1;
            m_pend_tgt  = tg;
            m_pend_kind = kind;
            m_pend_data = pc_d + 32'd8;
          end
        end else if (tk) begin
          m_pc = tg;
          ras_apply(kind, pc_d + 32'd8, reg_target);
        end else begin
          m_pc = m_pc + 32'd4;
        end
      end
      check("redirect", {31'b0, redirect}, {31'b0, exp_redir});
    end
    last_redirect = redirect;
    @(posedge clk);
    #1;
    check("pc_f", pc_f, m_pc);
    check("ras_hit", {31'b0, ras_hit}, {31'b0, m_hit});
    @(negedge clk);
  endtask

  task automatic idle();
    br_valid = 1'b0;
    trans_op = 4'd0;
    link     = 1'b0;
    is_ret   = 1'b0;
  endtask

  function automatic logic [31:0] pick_val();
    case ($urandom_range(0, 4))
      0:       return 32'h0;
      1:       return 32'h1;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int pulses;
    reset = 1'b0; stall = 1'b1; idle();
    pc_d = 32'h0; cmp_a = 32'h0; cmp_b = 32'h0; offset = 16'h0;
    instr_index = 26'h0; reg_target = 32'h0;
    @(negedge clk);

    // Reset dominates a raised stall
    tick(); tick();
    check("reset_pc", pc_f, 32'h0000_3000);
    check("reset_ras_hit", {31'b0, ras_hit}, 32'h0);

    // Sequential fetch after release
    reset = 1'b1; stall = 1'b0;
    #1 check("pc_after_release", pc_f, 32'h0000_3000);
    tick(); check("seq_3004", pc_f, 32'h0000_3004);
    tick(); check("seq_3008", pc_f, 32'h0000_3008);

    // Taken BEQ with offset -1 lands on itself
    br_valid = 1'b1; trans_op = 4'd1; pc_d = 32'h0000_3010;
    cmp_a = 32'd5; cmp_b = 32'd5; offset = 16'hFFFF;
    tick();
    check("beq_redirect", {31'b0, last_redirect}, 32'h1);
    check("beq_target", pc_f, 32'h0000_3010);

    // BNE with equal operands falls through
    trans_op = 4'd2;
    tick();
    check("bne_redirect", {31'b0, last_redirect}, 32'h0);
    check("bne_pc", pc_f, 32'h0000_3014);

    // J held by a 3-cycle stall; later D-stage inputs are ignored while pending
    pulses = 0;
    trans_op = 4'd7; pc_d = 32'h0000_3020; instr_index = 26'h0000C00; stall = 1'b1;
    tick(); pulses += int'(last_redirect);
    instr_index = 26'h0000100;
    tick(); pulses += int'(last_redirect);
    trans_op = 4'd8; reg_target = 32'h0000_5000;
    tick(); pulses += int'(last_redirect);
    check("stall_hold_pc", pc_f, 32'h0000_3014);
    stall = 1'b0; idle();
    tick(); pulses += int'(last_redirect);
    check("pend_target", pc_f, 32'h0000_3000);
    tick(); pulses += int'(last_redirect);
    check("after_pend_pc", pc_f, 32'h0000_3004);
    check("redirect_pulses", 32'(pulses), 32'd1);

    // Wrap at 2^32
    br_valid = 1'b1; trans_op = 4'd8; reg_target = 32'hFFFF_FFFC;
    tick();
    check("jr_to_top", pc_f, 32'hFFFF_FFFC);
    idle();
    tick();
    check("wrap_zero", pc_f, 32'h0000_0000);

    // Reset discards a pending redirect
    br_valid = 1'b1; trans_op = 4'd7; instr_index = 26'h0000400; stall = 1'b1;
    tick();
    idle(); reset = 1'b0;
    tick();
    reset = 1'b1; stall = 1'b0;
    tick();
    check("reset_clears_pend", pc_f, 32'h0000_3004);

    // Return stack: 5 linked calls, then 5 matching returns (newest first)
    for (int i = 0; i < 5; i++) begin
      br_valid = 1'b1; trans_op = 4'd7; link = 1'b1;
      pc_d = 32'h0000_4000 + 32'(i) * 32'h100; instr_index = 26'h0002000;
      tick();
    end
    link = 1'b0;
    for (int i = 4; i >= 0; i--) begin
      br_valid = 1'b1; trans_op = 4'd8; is_ret = 1'b1;
      reg_target = 32'h0000_4008 + 32'(i) * 32'h100;
      tick();
      check("ras_return_hit", {31'b0, ras_hit}, {31'b0, RAS_ON && (i > 0)});
    end
    idle();

    // Randomized traffic
    for (int c = 0; c < 600; c++) begin
      reset       = ($urandom_range(0, 99) != 0);
      stall       = ($urandom_range(0, 9) < 3);
      br_valid    = $urandom_range(0, 1);
      trans_op    = 4'($urandom_range(0, 15));
      link        = $urandom_range(0, 1);
      is_ret      = $urandom_range(0, 1);
      pc_d        = $urandom & 32'hFFFF_FFFC;
      cmp_a       = pick_val();
      cmp_b       = $urandom_range(0, 1) ? cmp_a : pick_val();
      offset      = 16'($urandom);
      instr_index = 26'($urandom);
      reg_target  = (RAS_ON && ras.size() > 0 && $urandom_range(0, 1)) ? ras[$] : $urandom;
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_gen.md
PC_GEN -- requirements
Module: pc_gen

Interface
REQ-001 SHALL have parameter WIDTH, default 32, address width; values below 32 are illegal.
REQ-002 SHALL have parameter RESET_PC, default 32'h3000, the value pc_f takes at reset.
REQ-003 SHALL have parameter RAS_DEPTH, default 4, the return-address stack entry count; it SHALL be a power of two, at least 2.
REQ-004 SHALL provide: clk  in  1  single clock, rising edge.
REQ-005 SHALL provide: reset  in  1  synchronous, active-low reset (0 = reset); one clock, reset synchronous and active-low.
REQ-006 SHALL provide: stall  in  1  freezes pc_f.
REQ-007 SHALL provide: br_valid  in  1  the D-stage control-transfer inputs are valid this cycle.
REQ-008 SHALL provide: trans_op  in  4  0 NEXT, 1 BEQ, 2 BNE, 3 BLEZ, 4 BGTZ, 5 BLTZ, 6 BGEZ, 7 J, 8 JR; all other codes are treated as NEXT.
REQ-009 SHALL provide: link, is_ret  in  1 each  J/JR writes a link; JR is a return.
REQ-010 SHALL provide: pc_d  in  WIDTH  address of the branch instruction.
REQ-011 SHALL provide: cmp_a, cmp_b  in  WIDTH each  operands for the branch compare.
REQ-012 SHALL provide: offset  in  16  branch offset; instr_index  in  26  jump index; reg_target  in  WIDTH  JR target.
REQ-013 SHALL provide: pc_f  out  WIDTH  current fetch PC (registered).
REQ-014 SHALL provide: redirect  out  1  a taken transfer is being applied this cycle (combinational).
REQ-015 SHALL provide: link_addr  out  WIDTH  pc_d+8.
REQ-016 SHALL provide: ras_hit  out  1  registered one-cycle pulse when a return matched the RAS top.

Function
REQ-017 Compares SHALL be signed on cmp_a (BLEZ/BGTZ/BLTZ/BGEZ) or cmp_a==cmp_b (BEQ/BNE); a taken branch targets pc_d+4+sext(offset)<<2, modulo 2^WIDTH.
REQ-018 The J target SHALL be {(pc_d+4)[WIDTH-1:28], instr_index, 2'b00}; the JR target SHALL be reg_target unchanged, with no alignment check.
REQ-019 Without a redirect and with stall=0, pc_f SHALL become pc_f+4 at the next edge, wrapping at 2^WIDTH.
REQ-020 A taken transfer with br_valid=1 and stall=0 in cycle N SHALL set redirect=1 in cycle N and pc_f=target at N+1 (delay slot already fetched).
REQ-021 A taken transfer with stall=1 SHALL be latched into a pending register (pend_valid, pend_target), leaving pc_f held.
REQ-022 Further br_valid inputs SHALL be ignored while pend_valid=1.
REQ-023 In the first cycle with stall=0, the pending target SHALL be loaded into pc_f, redirect SHALL be 1, and pend_valid SHALL clear.
REQ-024 State machine: RUN (no pending) -> HOLD on taken&&stall; HOLD -> RUN on !stall.
REQ-025 An untaken branch or NEXT SHALL never enter HOLD.
REQ-026 link_addr SHALL be combinational pc_d+8 regardless of trans_op.

Reset
REQ-027 With reset=0 at an edge: pc_f=RESET_PC, pend_valid=0, state RUN, ras_hit=0, RAS pointer=0, count=0; RAS entry contents are don't-care.
REQ-028 Reset SHALL override stall and any pending redirect in the same cycle.

Configuration
REQ-029 Macro PC_GEN_RAS_EN SHALL control the RAS.
REQ-030 When PC_GEN_RAS_EN is defined, an accepted J with link=1 SHALL push pc_d+8.
REQ-031 When PC_GEN_RAS_EN is defined, an accepted JR with is_ret=1 SHALL pop, and ras_hit SHALL pulse at N+1 if top==reg_target.
REQ-032 A push on a full RAS SHALL overwrite the oldest entry (circular), with count saturating at RAS_DEPTH.
REQ-033 A pop on an empty RAS SHALL leave the pointer unchanged and ras_hit=0.
REQ-034 When PC_GEN_RAS_EN is undefined, no RAS storage SHALL exist and ras_hit SHALL be tied to 0.
REQ-035 RAS state SHALL update only when the transfer is applied (stall=0), never on latch-into-HOLD.

Structure
REQ-036 Package pc_gen_pkg SHALL hold the trans_op encodings and the RESET_PC default.
REQ-037 One sub-module, pc_gen_ras (circular stack), SHALL be instantiated only under PC_GEN_RAS_EN.

Verification
REQ-038 Bench SHALL check: reset=0 then release, stall=0 -> pc_f 0x3000, 0x3004, 0x3008.
REQ-039 Bench SHALL check: pc_d=0x3010, BEQ, cmp_a=cmp_b=5, offset=0xFFFF -> redirect=1, next pc_f=0x3010.
REQ-040 Bench SHALL check: BNE with equal operands -> redirect=0, pc_f increments by 4.
REQ-041 Bench SHALL check: J instr_index=0x0000C00 with stall=1 for 3 cycles -> pc_f held, then 0x00003000 on the first unstalled edge, redirect pulses once.
REQ-042 Bench SHALL check: pc_f=0xFFFFFFFC, no redirect -> pc_f wraps to 0x00000000.
REQ-043 Bench SHALL check with PC_GEN_RAS_EN: 5 linked J pushes (RAS_DEPTH=4), then 5 JR is_ret with matching reg_target -> ras_hit on the 4 newest, 0 on the 5th.
